// File: rtl/power.sv
// Purpose : iterative Q10.10 -> Q30.10 integer power x^n (n = 0..7), one shared multiplier.
// Latency : max(n,1)+1 cycles from the in_valid cycle to the out_valid cycle.
// Backpr. : none; in_valid outside IDLE is dropped, out_valid is a one-cycle strobe.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request strobe, only honoured in IDLE
//   in_data_1  base x, unsigned Q10.10 (20 bits)
//   in_data_2  exponent n, unsigned 0..7
//   out_valid  one-cycle result strobe
//   out_data   x^n, unsigned Q30.10 (40 bits), held until next result or reset
//   out_sat    result clamped to all-ones, held with out_data
module power (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [19:0] in_data_1,
    input  logic [2:0]  in_data_2,
    output logic        out_valid,
    output logic [39:0] out_data,
    output logic        out_sat
);

    // Fractional bit count of both operand and result; fixed by the number format.
    localparam int FRAC = 10;

    localparam logic [39:0] ONE_Q10 = 40'h00_0000_0400;
    localparam logic [39:0] SAT_VAL = 40'hFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DUMP = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [19:0] base, base_nxt;
    logic [39:0] acc,  acc_nxt;
    logic [2:0]  cnt,  cnt_nxt;
    logic        sat,  sat_nxt;

    logic        out_valid_nxt;
    logic [39:0] out_data_nxt;
    logic        out_sat_nxt;

    // Single shared multiplier. The full product is Q40.20 (60 bits); dropping
    // FRAC low bits by truncation gives a Q40.10 value whose top 10 bits must
    // be zero for the result to fit the Q30.10 accumulator.
    logic [49:0] q;
    logic        ovf;

    assign q   = 50'((60'(acc) * 60'(base)) >> FRAC);
    assign ovf = |q[49:40];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        sat_nxt       = sat;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_sat_nxt   = out_sat;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    base_nxt = in_data_1;
                    sat_nxt  = 1'b0;
                    // x^1 is the base itself, so the accumulator is preloaded
                    // with x and only n-1 multiplies remain; x^0 is exactly 1.0.
                    if (in_data_2 != 3'd0) begin
                        acc_nxt = {20'd0, in_data_1};
                        cnt_nxt = in_data_2 - 3'd1;
                    end else begin
                        acc_nxt = ONE_Q10;
                        cnt_nxt = 3'd0;
                    end
                    state_nxt = MULT;
                end
            end

            MULT: begin
                if (cnt != 3'd0) begin
                    // Saturation is sticky: once clamped, further multiplies
                    // would only produce garbage from the all-ones pattern.
                    if (sat || ovf) begin
                        acc_nxt = SAT_VAL;
                        sat_nxt = 1'b1;
                    end else begin
                        acc_nxt = q[39:0];
                    end
                    cnt_nxt = cnt - 3'd1;
                end else begin
                    out_data_nxt  = acc;
                    out_sat_nxt   = sat;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DUMP;
                end
            end

            DUMP: begin
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            base      <= base_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            sat       <= sat_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_sat   <= out_sat_nxt;
        end
    end

endmodule
